// File: rtl/pc_seq_if.sv
// Bus bundle for pc_seq: run/fetch handshake, branch request channel and PC command strobes.
interface pc_seq_if;
   logic        run;
   logic        mem_ack;
   logic        br_valid;
   logic        br_dir;
   logic [15:0] br_offset;
   logic        flush;
   logic        br_ready;
   logic        fetch_req;
   logic        inc;
   logic        add;
   logic        sub;
   logic [15:0] offset;
   logic        busy;
   logic [15:0] fetch_count;

   modport master (
      output run, mem_ack, br_valid, br_dir, br_offset, flush,
      input  br_ready, fetch_req, inc, add, sub, offset, busy, fetch_count
   );

   modport slave (
      input  run, mem_ack, br_valid, br_dir, br_offset, flush,
      output br_ready, fetch_req, inc, add, sub, offset, busy, fetch_count
   );
endinterface

// File: rtl/pc_seq.sv
// PC sequencer: IDLE/FETCH fetch loop issuing inc/add/sub on each memory ack, with a branch buffer.
// PC_SEQ_BRFIFO_EN defined: 4-entry branch FIFO; undefined: single holding register.
module pc_seq (
   input  logic     clk,
   input  logic     reset,
   pc_seq_if.slave  bus
);
   typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_e;

   state_e      state_q, state_d;
   logic [15:0] fetch_count_q, fetch_count_d;
   logic        ack_ok, take_branch, push, pop, full, empty;
   logic        head_dir;
   logic [15:0] head_off;

   assign ack_ok      = (state_q == FETCH) && bus.mem_ack;
   assign take_branch = ack_ok && !empty && !bus.flush;
   assign bus.br_ready = !full && !bus.flush && !reset;
   assign push        = bus.br_valid && bus.br_ready;
   assign pop         = take_branch;

`ifdef PC_SEQ_BRFIFO_EN
   logic [16:0] fifo_mem_q [4];
   logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0]  count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 2'd1;
         if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
         count_d = count_q + 3'(push) - 3'(pop);
      end
   end

   // NOTE: entry storage is only read while occupied, so it carries no reset.
   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= {bus.br_dir, bus.br_offset};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign full  = (count_q == 3'd4);
   assign empty = (count_q == 3'd0);
   assign {head_dir, head_off} = fifo_mem_q[rd_ptr_q];
`else
   logic        hold_valid_q, hold_valid_d;
   logic [16:0] hold_data_q;

   always_comb begin
      hold_valid_d = hold_valid_q;
      if (bus.flush)  hold_valid_d = 1'b0;
      else if (push)  hold_valid_d = 1'b1;
      else if (pop)   hold_valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) hold_data_q <= {bus.br_dir, bus.br_offset};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) hold_valid_q <= 1'b0;
      else       hold_valid_q <= hold_valid_d;
   end

   assign full  = hold_valid_q;
   assign empty = !hold_valid_q;
   assign {head_dir, head_off} = hold_data_q;
`endif

   // State register and retired-fetch counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign fetch_count_d   = fetch_count_q + 16'(ack_ok);
   assign bus.fetch_count = fetch_count_q;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.run) state_d = FETCH;
         FETCH:   if (bus.mem_ack) state_d = bus.run ? FETCH : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.fetch_req = 1'b0;
      bus.busy      = 1'b0;
      bus.inc       = 1'b0;
      bus.add       = 1'b0;
      bus.sub       = 1'b0;
      bus.offset    = '0;
      if (state_q == FETCH) begin
         bus.fetch_req = 1'b1;
         bus.busy      = 1'b1;
         if (take_branch) begin
            bus.add    = !head_dir;
            bus.sub    = head_dir;
            bus.offset = head_off;
         end else if (bus.mem_ack) begin
            bus.inc = 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq; builds with or without PC_SEQ_BRFIFO_EN.
module tb_pc_seq;
`ifdef PC_SEQ_BRFIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif
   localparam logic [2:0] S_NONE = 3'b000, S_INC = 3'b100, S_ADD = 3'b010, S_SUB = 3'b001;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   logic [15:0] exp_count = '0;

   pc_seq_if bus ();
   pc_seq dut (.clk(clk), .reset(reset), .bus(bus.slave));

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      bus.run = 1'b0; bus.mem_ack = 1'b0; bus.br_valid = 1'b0;
      bus.br_dir = 1'b0; bus.br_offset = '0; bus.flush = 1'b0;
   endtask

   task automatic check_count(input string name);
      vectors++;
      if (bus.fetch_count !== exp_count) begin
         miscompares++;
         $display("FAIL %s: fetch_count got %h want %h", name, bus.fetch_count, exp_count);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; idle_inputs();
      @(negedge clk); bus.run = 1'b1; bus.mem_ack = 1'b1; bus.br_valid = 1'b1; #1;
      vectors++;
      if ({bus.fetch_req, bus.inc, bus.add, bus.sub, bus.busy, bus.br_ready} !== 6'b0 || bus.offset !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: req/inc/add/sub/busy/rdy=%b offset=%h want 0", {bus.fetch_req, bus.inc, bus.add, bus.sub, bus.busy, bus.br_ready}, bus.offset);
      end
      check_count("reset_count");
      @(negedge clk); idle_inputs(); reset = 1'b0; #1;
      vectors++;
      if (bus.br_ready !== 1'b1 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: br_ready=%b busy=%b want 1/0", bus.br_ready, bus.busy);
      end
      // ack while idle must be ignored
      @(negedge clk); bus.mem_ack = 1'b1; #1;
      vectors++;
      if ({bus.inc, bus.add, bus.sub} !== S_NONE) begin
         miscompares++;
         $display("FAIL idle_ack_strobe: got %b want %b", {bus.inc, bus.add, bus.sub}, S_NONE);
      end
      @(negedge clk); bus.mem_ack = 1'b0; #1;
      check_count("idle_ack_count");
   endtask

   task automatic test_inc();
      @(negedge clk); bus.run = 1'b1;
      @(negedge clk); #1;
      vectors++;
      if (bus.busy !== 1'b1 || bus.fetch_req !== 1'b1 || {bus.inc, bus.add, bus.sub} !== S_NONE) begin
         miscompares++;
         $display("FAIL fetch_entry: busy=%b req=%b strobes=%b want 1/1/000", bus.busy, bus.fetch_req, {bus.inc, bus.add, bus.sub});
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); bus.mem_ack = 1'b1; bus.run = (i < 2); #1;
         vectors++;
         if ({bus.inc, bus.add, bus.sub} !== S_INC || bus.offset !== 16'h0) begin
            miscompares++;
            $display("FAIL inc_ack[%0d]: strobes=%b offset=%h want %b/0000", i, {bus.inc, bus.add, bus.sub}, bus.offset, S_INC);
         end
      end
      exp_count += 16'd3;
      @(negedge clk); idle_inputs(); #1;
      check_count("inc_count");
      vectors++;
      if (bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL inc_idle: busy=%b want 0", bus.busy);
      end
   endtask

   task automatic test_branch_order();
      logic [2:0]  exp_s [3] = '{S_ADD, S_SUB, S_INC};
      logic [15:0] exp_o [3] = '{16'h0010, 16'h0004, 16'h0000};
      @(negedge clk); bus.br_valid = 1'b1; bus.br_dir = 1'b0; bus.br_offset = 16'h0010; #1;
      vectors++;
      if (bus.br_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL order_ready: br_ready=%b want 1", bus.br_ready);
      end
      @(negedge clk); bus.br_valid = (DEPTH > 1); bus.br_dir = 1'b1; bus.br_offset = 16'h0004;
      @(negedge clk); bus.br_valid = 1'b0; bus.run = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i == 1 && DEPTH == 1) begin
            @(negedge clk); bus.mem_ack = 1'b0; bus.br_valid = 1'b1; bus.br_dir = 1'b1; bus.br_offset = 16'h0004;
         end
         @(negedge clk); bus.br_valid = 1'b0; bus.mem_ack = 1'b1; bus.run = (i < 2); #1;
         vectors++;
         if ({bus.inc, bus.add, bus.sub} !== exp_s[i] || bus.offset !== exp_o[i]) begin
            miscompares++;
            $display("FAIL order[%0d]: strobes=%b offset=%h want %b/%h", i, {bus.inc, bus.add, bus.sub}, bus.offset, exp_s[i], exp_o[i]);
         end
      end
      exp_count += 16'd3;
      @(negedge clk); idle_inputs(); #1;
      check_count("order_count");
   endtask

   task automatic test_full();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); bus.br_valid = 1'b1; bus.br_dir = 1'b0; bus.br_offset = 16'(i + 1); #1;
         vectors++;
         if (bus.br_ready !== (i < DEPTH)) begin
            miscompares++;
            $display("FAIL full_ready[%0d]: br_ready=%b want %b", i, bus.br_ready, (i < DEPTH));
         end
      end
      @(negedge clk); bus.br_valid = 1'b0; bus.run = 1'b1; #1;
      vectors++;
      if (bus.br_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL full_hold: br_ready=%b want 0", bus.br_ready);
      end
      // drain: the accepted entries in order, then inc proves the rejected push left no trace
      for (int i = 0; i <= DEPTH; i++) begin
         @(negedge clk); bus.mem_ack = 1'b1; bus.run = (i < DEPTH); #1;
         vectors++;
         if ({bus.inc, bus.add, bus.sub} !== ((i < DEPTH) ? S_ADD : S_INC) ||
             bus.offset !== ((i < DEPTH) ? 16'(i + 1) : 16'h0)) begin
            miscompares++;
            $display("FAIL full_drain[%0d]: strobes=%b offset=%h", i, {bus.inc, bus.add, bus.sub}, bus.offset);
         end
      end
      exp_count += 16'(DEPTH + 1);
      @(negedge clk); idle_inputs(); #1;
      check_count("full_count");
      vectors++;
      if (bus.br_ready !== 1'b1 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL full_after: br_ready=%b busy=%b want 1/0", bus.br_ready, bus.busy);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk); bus.br_valid = 1'b1; bus.br_dir = 1'b0; bus.br_offset = 16'h0021;
      @(negedge clk); bus.br_valid = 1'b0; bus.run = 1'b1;
      @(negedge clk); bus.mem_ack = 1'b1; bus.br_valid = 1'b1; bus.br_dir = 1'b1; bus.br_offset = 16'h0022; #1;
      vectors++;
      if (bus.br_ready !== (DEPTH > 1) || {bus.inc, bus.add, bus.sub} !== S_ADD || bus.offset !== 16'h0021) begin
         miscompares++;
         $display("FAIL b2b_pushpop: rdy=%b strobes=%b offset=%h want %b/%b/0021", bus.br_ready, {bus.inc, bus.add, bus.sub}, bus.offset, (DEPTH > 1), S_ADD);
      end
      @(negedge clk); bus.br_valid = 1'b0; #1;
      vectors++;
      if ({bus.inc, bus.add, bus.sub} !== ((DEPTH > 1) ? S_SUB : S_INC) ||
          bus.offset !== ((DEPTH > 1) ? 16'h0022 : 16'h0000)) begin
         miscompares++;
         $display("FAIL b2b_second: strobes=%b offset=%h", {bus.inc, bus.add, bus.sub}, bus.offset);
      end
      @(negedge clk); bus.run = 1'b0; #1;
      vectors++;
      if ({bus.inc, bus.add, bus.sub} !== S_INC) begin
         miscompares++;
         $display("FAIL b2b_third: strobes=%b want %b", {bus.inc, bus.add, bus.sub}, S_INC);
      end
      exp_count += 16'd3;
      @(negedge clk); idle_inputs(); #1;
      check_count("b2b_count");
   endtask

   task automatic test_flush();
      @(negedge clk); bus.br_valid = 1'b1; bus.br_dir = 1'b0; bus.br_offset = 16'h0031;
      @(negedge clk); bus.br_dir = 1'b1; bus.br_offset = 16'h0032;
      @(negedge clk); bus.br_valid = 1'b0; bus.run = 1'b1;
      @(negedge clk); bus.flush = 1'b1; bus.mem_ack = 1'b1; #1;
      vectors++;
      if ({bus.inc, bus.add, bus.sub} !== S_INC || bus.offset !== 16'h0 || bus.br_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_ack: strobes=%b offset=%h rdy=%b want %b/0000/0", {bus.inc, bus.add, bus.sub}, bus.offset, bus.br_ready, S_INC);
      end
      @(negedge clk); bus.flush = 1'b0; bus.mem_ack = 1'b0; #1;
      vectors++;
      if (bus.br_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_ready: br_ready=%b want 1", bus.br_ready);
      end
      @(negedge clk); bus.mem_ack = 1'b1; bus.run = 1'b0; #1;
      vectors++;
      if ({bus.inc, bus.add, bus.sub} !== S_INC) begin
         miscompares++;
         $display("FAIL flush_empty: strobes=%b want %b", {bus.inc, bus.add, bus.sub}, S_INC);
      end
      exp_count += 16'd2;
      @(negedge clk); idle_inputs(); #1;
      check_count("flush_count");
   endtask

   task automatic test_zero_offset();
      @(negedge clk); bus.br_valid = 1'b1; bus.br_dir = 1'b1; bus.br_offset = 16'h0000;
      @(negedge clk); bus.br_valid = 1'b0; bus.run = 1'b1;
      @(negedge clk); bus.mem_ack = 1'b1; bus.run = 1'b0; #1;
      vectors++;
      if ({bus.inc, bus.add, bus.sub} !== S_SUB || bus.offset !== 16'h0) begin
         miscompares++;
         $display("FAIL zero_offset: strobes=%b offset=%h want %b/0000", {bus.inc, bus.add, bus.sub}, bus.offset, S_SUB);
      end
      exp_count += 16'd1;
      @(negedge clk); idle_inputs(); #1;
      check_count("zero_count");
   endtask

   task automatic test_hold();
      @(negedge clk); bus.run = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); bus.run = 1'b0; bus.mem_ack = 1'b0; #1;
         vectors++;
         if (bus.fetch_req !== 1'b1 || {bus.inc, bus.add, bus.sub} !== S_NONE) begin
            miscompares++;
            $display("FAIL hold[%0d]: req=%b strobes=%b want 1/000", i, bus.fetch_req, {bus.inc, bus.add, bus.sub});
         end
      end
      @(negedge clk); bus.mem_ack = 1'b1; #1;
      vectors++;
      if ({bus.inc, bus.add, bus.sub} !== S_INC) begin
         miscompares++;
         $display("FAIL hold_ack: strobes=%b want %b", {bus.inc, bus.add, bus.sub}, S_INC);
      end
      exp_count += 16'd1;
      @(negedge clk); bus.mem_ack = 1'b0; #1;
      vectors++;
      if (bus.busy !== 1'b0 || bus.fetch_req !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_idle: busy=%b req=%b want 0/0", bus.busy, bus.fetch_req);
      end
      check_count("hold_count");
   endtask

   task automatic test_wrap_and_reset();
      @(negedge clk); reset = 1'b1; idle_inputs();
      @(negedge clk); reset = 1'b0; exp_count = '0; #1;
      check_count("wrap_start");
      @(negedge clk); bus.run = 1'b1;
      @(negedge clk); bus.mem_ack = 1'b1;
      repeat (65535) @(negedge clk);
      #1;
      exp_count = 16'hFFFF;
      check_count("wrap_preload");
      @(negedge clk); #1;
      exp_count = 16'h0000;
      check_count("wrap_rollover");
      @(negedge clk); bus.mem_ack = 1'b0; #1;
      exp_count = 16'h0001;
      check_count("wrap_plus_one");
      // reset arrives mid-cycle while an ack is on the bus
      bus.mem_ack = 1'b1; #1; reset = 1'b1; #1;
      vectors++;
      if ({bus.fetch_req, bus.inc, bus.add, bus.sub, bus.busy, bus.br_ready} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_midfetch: req/inc/add/sub/busy/rdy=%b want 000000", {bus.fetch_req, bus.inc, bus.add, bus.sub, bus.busy, bus.br_ready});
      end
      exp_count = 16'h0000;
      check_count("reset_midfetch_count");
      @(negedge clk); idle_inputs(); reset = 1'b0; #1;
      vectors++;
      if (bus.br_ready !== 1'b1 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_midfetch_release: rdy=%b busy=%b want 1/0", bus.br_ready, bus.busy);
      end
      check_count("reset_midfetch_after");
   endtask

   initial begin
      test_reset();
      test_inc();
      test_branch_order();
      test_full();
      test_back_to_back();
      test_flush();
      test_zero_offset();
      test_hold();
      test_wrap_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 run  input  1  level; 1 = keep fetching, 0 = halt after any outstanding fetch completes.
REQ-004 mem_ack  input  1  single-cycle acknowledge of the current fetch.
REQ-005 br_valid  input  1  branch request valid.
REQ-006 br_dir  input  1  branch direction; 0 = forward (PC+offset), 1 = backward (PC-offset).
REQ-007 br_offset  input  16  unsigned branch distance.
REQ-008 flush  input  1  synchronous discard of all pending branches.
REQ-009 br_ready  output  1  branch buffer can accept a request this cycle.
REQ-010 fetch_req  output  1  fetch outstanding at the current PC.
REQ-011 inc, add, sub  output  1 each  PC command strobes, at most one high per cycle.
REQ-012 offset  output  16  PC offset operand.
REQ-013 busy  output  1  high in state FETCH.
REQ-014 fetch_count  output  16  number of retired fetches.

Function
REQ-015 The FSM SHALL have two states: IDLE and FETCH.
REQ-016 IDLE: fetch_req=0; if run=1, next state FETCH, otherwise stay in IDLE.
REQ-017 FETCH: fetch_req=1 until mem_ack; run=0 in FETCH without mem_ack SHALL NOT abandon the fetch.
REQ-018 On mem_ack in FETCH, the block SHALL assert exactly one strobe in that same cycle (combinational), so the PC updates on that clock edge:
  - branch pending: add (br_dir=0) or sub (br_dir=1) with offset=head br_offset; pop head.
  - no branch pending: inc with offset=0.
REQ-019 After mem_ack, next state is FETCH if run=1, else IDLE.
REQ-020 mem_ack outside FETCH SHALL be ignored: no strobe, no count change.
REQ-021 All strobes=0 and offset=0x0000 in every cycle without a qualifying mem_ack.
REQ-022 A branch is accepted when br_valid=1 and br_ready=1, storing {br_dir, br_offset}.
REQ-023 br_ready = !full && !flush && !reset; no same-cycle bypass when full.
REQ-024 When not full and not empty, a push and a pop in the same cycle SHALL both occur; occupancy is unchanged; FIFO order is kept.
REQ-025 flush=1 SHALL empty the buffer at the next edge and takes priority over a same-cycle pop. A mem_ack in that cycle SHALL issue inc.
REQ-026 br_offset=0 is a legal branch and issues add/sub with offset 0.
REQ-027 fetch_count SHALL increment by 1 on each qualifying mem_ack and wrap 0xFFFF->0x0000.

Reset
REQ-028 Asynchronous reset SHALL force: state IDLE, buffer empty, fetch_count=0x0000.
REQ-029 While reset=1: fetch_req=0, inc=add=sub=0, offset=0x0000, busy=0, br_ready=0.
REQ-030 Reset during an outstanding fetch SHALL abandon it; no strobe is issued.
REQ-031 After reset release, br_ready=1 and the FSM waits for run=1.

Configuration
REQ-032 Macro PC_SEQ_BRFIFO_EN:
  - defined: branch buffer is a 4-entry FIFO; full at 4 entries.
  - undefined: buffer is a single holding register; full at 1 entry; push and pop never coincide because br_ready=0 when full.
REQ-033 All other behaviour SHALL be identical in both builds.

Verification
REQ-034 Reset release, run=1, three mem_acks -> inc strobed on each ack cycle, fetch_count=3, add=sub=0 throughout.
REQ-035 Push {dir=0, off=0x0010}, then {dir=1, off=0x0004}, then ack, ack, ack -> add/0x0010, then sub/0x0004, then inc, in that order.
REQ-036 Back-to-back branch pushes with no ack -> br_ready falls after 1 push (macro off) or after 4 pushes (macro on); a 5th push is not accepted.
REQ-037 Two entries pending, flush and mem_ack in the same cycle -> inc issued, buffer empty, br_ready=1 next cycle.
REQ-038 run=0 while in FETCH with no ack for 5 cycles -> fetch_req stays 1; ack -> inc, then IDLE, busy=0.
REQ-039 fetch_count preloaded to 0xFFFF by 65535 acks, one more ack -> fetch_count=0x0000; reset mid-fetch -> no strobe, count=0.
